// File: rtl/axi_chan_buffer_if.sv
`default_nettype none
// =============================================================================
// axi_chan_buffer_if : valid/ready/payload/last bundle for one AXI channel
// Rev 1.0
// =============================================================================
interface axi_chan_buffer_if #(
  parameter int DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface
`default_nettype wire

// File: rtl/axi_chan_buffer.sv
`default_nettype none
// =============================================================================
// axi_chan_buffer : single-clock AXI channel FIFO with optional store-and-forward
// Rev 1.0
// =============================================================================
module axi_chan_buffer #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 4,
  parameter int PKT_MODE = 0,
  parameter int CW       = $clog2(DEPTH) + 1
) (
  input  wire            aclk,
  input  wire            aresetn,
  input  wire            flush,
  axi_chan_buffer_if.slave  s,
  axi_chan_buffer_if.master m,
  output logic [CW-1:0]  level,
  output logic [CW-1:0]  pkts
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);

  logic [DATA_W-1:0] mem_q  [DEPTH];
  logic              last_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     level_q, level_d;
  logic [CW-1:0]     pkts_q, pkts_d;
  logic              cut_q, cut_d;
  logic              s_ready_q, s_ready_d;

  logic              m_valid_w;
  logic              m_last_w;
  logic              push;
  logic              pop;

  assign m_last_w = last_q[rd_ptr_q];

  // Packet mode releases beats only for complete bursts, or once a full
  // buffer with no complete burst forces cut-through to avoid deadlock.
  always_comb begin
    if (PKT_MODE != 0) begin
      m_valid_w = cut_q ? (level_q != '0) : (pkts_q != '0);
    end else begin
      m_valid_w = (level_q != '0);
    end
  end

  assign push = s.valid && s_ready_q;
  assign pop  = m_valid_w && m.ready;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    pkts_d    = pkts_q;
    cut_d     = cut_q;
    s_ready_d = s_ready_q;

    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      level_d   = '0;
      pkts_d    = '0;
      cut_d     = 1'b0;
      s_ready_d = 1'b1;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

      case ({push, pop})
        2'b10:   level_d = level_q + CW'(1);
        2'b01:   level_d = level_q - CW'(1);
        default: level_d = level_q;
      endcase

      case ({push && s.last, pop && m_last_w})
        2'b10:   pkts_d = pkts_q + CW'(1);
        2'b01:   pkts_d = pkts_q - CW'(1);
        default: pkts_d = pkts_q;
      endcase

      // Set from next-state values so m_valid rises the cycle after fill.
      cut_d = (cut_q && !(pop && m_last_w)) ||
              ((level_d == FULL_LVL) && (pkts_d == '0));

      s_ready_d = (level_d != FULL_LVL);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      pkts_q    <= '0;
      cut_q     <= 1'b0;
      s_ready_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      pkts_q    <= pkts_d;
      cut_q     <= cut_d;
      s_ready_q <= s_ready_d;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i]  <= '0;
        last_q[i] <= 1'b0;
      end
    end else if (push && !flush) begin
      mem_q[wr_ptr_q]  <= s.data;
      last_q[wr_ptr_q] <= s.last;
    end
  end

  assign s.ready = s_ready_q;
  assign m.valid = m_valid_w;
  assign m.data  = mem_q[rd_ptr_q];
  assign m.last  = m_last_w;
  assign level   = level_q;
  assign pkts    = pkts_q;

endmodule
`default_nettype wire
